mfp_ahb_rojobot_if: RTL and testbench

AHB-Lite slave that connects the MIPSfpga bus to the rojobot31 register set. It sits between mfp_sys's AHB fabric (upstream) and rojobot31 (downstream).
- Drives MotCtl_in and Bot_Config_reg from CPU writes.
- Snapshots LocX/LocY/Sensors/BotInfo on each upd_sysregs rising edge.
- Keeps a sticky update-sync flag with software acknowledge, an overrun counter and an optional interrupt.
- The bot and this block share HCLK; the top level must clock rojobot31 from the same clock.

---
 rtl/mfp_ahb_rojobot_if.sv | 87 ++++++++
 tb/tb_mfp_ahb_rojobot_if.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_rojobot_if.sv
// mfp_ahb_rojobot_if: AHB-Lite slave bridging the MIPSfpga bus to the rojobot31 register set.
// Zero-wait, OKAY-only; writes commit at the end of the data phase, reads are registered in the address phase.
module mfp_ahb_rojobot_if #(
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [1:0]  HTRANS,
   input  logic        HREADY,
   input  logic        HWRITE,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   input  logic [7:0]  bot_loc_x,
   input  logic [7:0]  bot_loc_y,
   input  logic [7:0]  bot_sensors,
   input  logic [7:0]  bot_info,
   input  logic        upd_sysregs,
   output logic [7:0]  mot_ctl,
   output logic [7:0]  bot_config,
   output logic        bot_irq
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic              w_acc, w_wr_ack, w_wr_clr, w_edge, w_ovr, w_unused;
   logic [ADDR_W-1:0] w_haddr, r_addr;
   logic [31:0]       w_rd, r_hrdata, r_snap;
   logic [CNT_W-1:0]  w_upd_inc, w_ovr_inc, r_upd_cnt, r_ovr_cnt;
   logic [7:0]        r_mot, r_cfg;
   logic              r_wr, r_irq_en, r_flag, r_upd_d;

   assign w_acc     = HSEL & HTRANS[1] & HREADY;
   assign w_haddr   = HADDR[ADDR_W+1:2];
   assign w_wr_ack  = r_wr && r_addr == ADDR_W'(4) && HWDATA[0];
   assign w_wr_clr  = r_wr && r_addr == ADDR_W'(6) && HWDATA[0];
   assign w_edge    = upd_sysregs & ~r_upd_d;
   // an ACK landing on the same edge absorbs the event, so it is not an overrun
   assign w_ovr     = w_edge & r_flag & ~w_wr_ack;
   assign w_upd_inc = (r_upd_cnt == CNT_MAX) ? r_upd_cnt : r_upd_cnt + CNT_W'(1);
   assign w_ovr_inc = (r_ovr_cnt == CNT_MAX) ? r_ovr_cnt : r_ovr_cnt + CNT_W'(1);
   assign w_unused  = ^{HTRANS[0], HADDR[31:ADDR_W+2], HADDR[1:0], HWDATA[31:9]};

   assign HRDATA     = r_hrdata;
   assign mot_ctl    = r_mot;
   assign bot_config = r_cfg;
   assign bot_irq    = r_flag & r_irq_en;

   always_comb begin
      w_rd = 32'h0;
      case (w_haddr)
         ADDR_W'(0): w_rd = r_snap;
         ADDR_W'(1): w_rd = {24'h0, r_mot};
         ADDR_W'(2): w_rd = {23'h0, r_irq_en, r_cfg};
         ADDR_W'(3): w_rd = {31'h0, r_flag};
         ADDR_W'(5): w_rd = {16'(r_ovr_cnt), 16'(r_upd_cnt)};
         default:    w_rd = 32'h0;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_addr    <= '0;
         r_wr      <= 1'b0;
         r_hrdata  <= 32'h0;
         r_mot     <= 8'h0;
         r_cfg     <= 8'h0;
         r_irq_en  <= 1'b0;
         r_flag    <= 1'b0;
         r_snap    <= 32'h0;
         r_upd_cnt <= '0;
         r_ovr_cnt <= '0;
         r_upd_d   <= 1'b0;
      end else begin
         r_upd_d <= upd_sysregs;
         r_wr    <= w_acc & HWRITE;
         if (w_acc) r_addr <= w_haddr;
         if (w_acc & ~HWRITE) r_hrdata <= w_rd;
         if (r_wr && r_addr == ADDR_W'(1)) r_mot <= HWDATA[7:0];
         if (r_wr && r_addr == ADDR_W'(2)) {r_irq_en, r_cfg} <= HWDATA[8:0];
         r_flag <= w_edge | (r_flag & ~w_wr_ack);
         if (w_edge) r_snap <= {bot_loc_x, bot_loc_y, bot_sensors, bot_info};
         r_upd_cnt <= w_wr_clr ? CNT_W'(w_edge) : (w_edge ? w_upd_inc : r_upd_cnt);
         r_ovr_cnt <= w_wr_clr ? CNT_W'(w_ovr) : (w_ovr ? w_ovr_inc : r_ovr_cnt);
      end
   end
endmodule

// File: tb/tb_mfp_ahb_rojobot_if.sv
// tb_mfp_ahb_rojobot_if: directed vector table, multi-cycle corner sequences and a
// randomized phase checked against a register-level reference model.
module tb_mfp_ahb_rojobot_if;
   logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic [31:0] HADDR = 32'h0, HWDATA = 32'h0, HRDATA;
   logic [7:0]  bot_loc_x = 8'h0, bot_loc_y = 8'h0, bot_sensors = 8'h0, bot_info = 8'h0;
   logic        upd_sysregs = 1'b0;
   logic [7:0]  mot_ctl, bot_config;
   logic        bot_irq;

   int n_pass = 0, n_tot = 0;

   // reference model state
   logic [31:0] m_snap;
   logic [7:0]  m_mot, m_cfg;
   logic        m_ien, m_flag;
   int          m_upd, m_ovr;

   mfp_ahb_rojobot_if dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(HREADY),
      .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .bot_loc_x(bot_loc_x), .bot_loc_y(bot_loc_y), .bot_sensors(bot_sensors),
      .bot_info(bot_info), .upd_sysregs(upd_sysregs), .mot_ctl(mot_ctl),
      .bot_config(bot_config), .bot_irq(bot_irq)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      int          op;
      int          addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;
   localparam int OP_W = 0, OP_R = 1, OP_P = 2, OP_H = 3, OP_PIN = 4;
   vec_t tv[$];

   task automatic add(input int op, input int a, input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      v.op = op; v.addr = a; v.data = d; v.exp = e;
      tv.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s got=%h want=%h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] pins();
      return {15'h0, bot_irq, bot_config, mot_ctl};
   endfunction

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   function automatic void model_reset();
      m_snap = 0; m_mot = 0; m_cfg = 0; m_ien = 0; m_flag = 0; m_upd = 0; m_ovr = 0;
   endfunction

   function automatic void model_write(input int a, input logic [31:0] d);
      case (a)
         1: m_mot = d[7:0];
         2: begin m_cfg = d[7:0]; m_ien = d[8]; end
         4: if (d[0]) m_flag = 1'b0;
         6: if (d[0]) begin m_upd = 0; m_ovr = 0; end
         default: ;
      endcase
   endfunction

   function automatic void model_pulse(input logic [31:0] v);
      if (m_flag) m_ovr = sat(m_ovr);
      m_flag = 1'b1;
      m_upd  = sat(m_upd);
      m_snap = v;
   endfunction

   function automatic logic [31:0] model_read(input int a);
      case (a)
         0: return m_snap;
         1: return {24'h0, m_mot};
         2: return {23'h0, m_ien, m_cfg};
         3: return {31'h0, m_flag};
         5: return (m_ovr << 16) | m_upd;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] model_pins();
      return {15'h0, m_flag & m_ien, m_cfg, m_mot};
   endfunction

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
   endtask

   task automatic addr_ph(input int a, input logic w);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a << 2;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      addr_ph(a, 1'b1);
      tick();
      idle();
      HWDATA = d;
      tick();
      model_write(a, d);
   endtask

   task automatic rd(input int a, output logic [31:0] v);
      addr_ph(a, 1'b0);
      tick();
      idle();
      v = HRDATA;
   endtask

   task automatic set_bot(input logic [31:0] v);
      {bot_loc_x, bot_loc_y, bot_sensors, bot_info} = v;
   endtask

   task automatic hold_upd(input int n, input logic [31:0] v);
      set_bot(v);
      upd_sysregs = 1'b1;
      repeat (n) tick();
      upd_sysregs = 1'b0;
      tick();
      model_pulse(v);
   endtask

   // write whose data phase lines up with an upd_sysregs rising edge
   task automatic wr_with_edge(input int a, input logic [31:0] d, input logic [31:0] bv);
      addr_ph(a, 1'b1);
      tick();
      idle();
      HWDATA = d;
      set_bot(bv);
      upd_sysregs = 1'b1;
      tick();
      upd_sysregs = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] v;
      int a, op;
      model_reset();
      // reset state
      for (int i = 0; i < 8; i++) add(OP_R, i, 0, 32'h0);
      add(OP_PIN, 0, 0, 32'h0);
      // register writes and readback
      add(OP_W, 1, 32'h000000A5, 0);    add(OP_R, 1, 0, 32'h000000A5); add(OP_PIN, 0, 0, 32'h000A5);
      add(OP_W, 2, 32'h000001F3, 0);    add(OP_R, 2, 0, 32'h000001F3); add(OP_PIN, 0, 0, 32'h0F3A5);
      // first update event
      add(OP_P, 0, 32'h12345678, 0);    add(OP_R, 0, 0, 32'h12345678);
      add(OP_R, 3, 0, 32'h1);           add(OP_R, 5, 0, 32'h1);         add(OP_PIN, 0, 0, 32'h1F3A5);
      add(OP_W, 4, 32'h1, 0);           add(OP_R, 3, 0, 32'h0);         add(OP_PIN, 0, 0, 32'h0F3A5);
      add(OP_R, 4, 0, 32'h0);
      add(OP_W, 6, 32'h1, 0);           add(OP_R, 5, 0, 32'h0);
      // three events without ACK, then a long-held strobe
      add(OP_P, 0, 32'h01020304, 0);    add(OP_P, 0, 32'h11223344, 0);  add(OP_P, 0, 32'hAABBCCDD, 0);
      add(OP_R, 5, 0, 32'h00020003);    add(OP_R, 0, 0, 32'hAABBCCDD);
      add(OP_H, 10, 32'h55667788, 0);   add(OP_R, 5, 0, 32'h00030004);  add(OP_R, 0, 0, 32'h55667788);
      // no-effect writes and read-only / unused offsets
      add(OP_W, 6, 32'h0, 0);           add(OP_R, 5, 0, 32'h00030004);
      add(OP_W, 4, 32'hFFFFFFFE, 0);    add(OP_R, 3, 0, 32'h1);
      add(OP_W, 7, 32'hFFFFFFFF, 0);    add(OP_R, 7, 0, 32'h0);
      add(OP_W, 0, 32'hFFFFFFFF, 0);    add(OP_R, 0, 0, 32'h55667788);
      add(OP_W, 3, 32'h0, 0);           add(OP_R, 3, 0, 32'h1);
      add(OP_W, 5, 32'h0, 0);           add(OP_R, 5, 0, 32'h00030004);
      add(OP_W, 1, 32'hFFFFFF3C, 0);    add(OP_R, 1, 0, 32'h0000003C);
      add(OP_W, 6, 32'h1, 0);           add(OP_R, 5, 0, 32'h0);         add(OP_R, 3, 0, 32'h1);

      repeat (3) tick();
      HRESETn = 1'b1;
      tick();

      foreach (tv[i]) begin
         case (tv[i].op)
            OP_W: wr(tv[i].addr, tv[i].data);
            OP_R: begin rd(tv[i].addr, v); chk($sformatf("vec%0d_rd%0d", i, tv[i].addr), v, tv[i].exp); end
            OP_P: hold_upd(1, tv[i].data);
            OP_H: hold_upd(tv[i].addr, tv[i].data);
            default: chk($sformatf("vec%0d_pins", i), pins(), tv[i].exp);
         endcase
      end

      // ACK commit coincides with an update edge: set wins, no overrun
      wr_with_edge(4, 32'h1, 32'h0A0B0C0D);
      rd(3, v); chk("ack_edge_flag", v, 32'h1);
      rd(5, v); chk("ack_edge_count", v, 32'h00000001);
      rd(0, v); chk("ack_edge_snap", v, 32'h0A0B0C0D);
      // CLR coincides with an overrunning update edge
      wr_with_edge(6, 32'h1, 32'h01010101);
      rd(5, v); chk("clr_edge_ovr", v, 32'h00010001);
      // CLR coincides with a non-overrunning edge
      wr(4, 32'h1);
      rd(3, v); chk("ack_clears", v, 32'h0);
      wr_with_edge(6, 32'h1, 32'h02020202);
      rd(5, v); chk("clr_edge_noovr", v, 32'h00000001);
      rd(3, v); chk("clr_edge_flag", v, 32'h1);
      // SNAP read address phase coincides with an update edge: old snapshot
      set_bot(32'hDEADBEEF);
      upd_sysregs = 1'b1;
      addr_ph(0, 1'b0);
      tick();
      idle();
      upd_sysregs = 1'b0;
      chk("snap_rd_edge_old", HRDATA, 32'h02020202);
      tick();
      rd(0, v); chk("snap_rd_edge_new", v, 32'hDEADBEEF);
      // back-to-back write then read of the same register: old value
      addr_ph(1, 1'b1);
      tick();
      HWDATA = 32'h5A;
      addr_ph(1, 1'b0);
      tick();
      idle();
      chk("b2b_rd_old", HRDATA, 32'h3C);
      rd(1, v); chk("b2b_rd_new", v, 32'h5A);
      chk("b2b_pins", pins(), 32'h1F35A);
      // asynchronous reset in the middle of a transfer
      rd(1, v);
      addr_ph(2, 1'b1);
      @(posedge HCLK);
      #3;
      HRESETn = 1'b0;
      #1;
      chk("async_hrdata", HRDATA, 32'h0);
      chk("async_pins", pins(), 32'h0);
      idle();
      model_reset();
      tick();
      tick();
      HRESETn = 1'b1;
      rd(1, v); chk("post_rst_mot", v, 32'h0);
      rd(5, v); chk("post_rst_count", v, 32'h0);
      wr(1, 32'h77);
      rd(1, v); chk("post_rst_wr", v, 32'h77);
      chk("post_rst_pins", pins(), model_pins());

      // randomized traffic against the reference model
      for (int k = 0; k < 400; k++) begin
         op = $urandom_range(0, 2);
         a  = $urandom_range(0, 7);
         if (op == 0) wr(a, $urandom);
         else if (op == 1) begin rd(a, v); chk($sformatf("rnd%0d_rd%0d", k, a), v, model_read(a)); end
         else hold_upd($urandom_range(1, 4), $urandom);
         chk($sformatf("rnd%0d_pins", k), pins(), model_pins());
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
